// File: rtl/fod_phase_ctrl_if.sv
// Handshake/data bundle between the FOD controller and its host.
// Params: FCW_I_W, FCW_F_W. master = host side, slave = controller side.
interface fod_phase_ctrl_if #(
  parameter int FCW_I_W = 6,
  parameter int FCW_F_W = 16
);
  logic               en;
  logic [FCW_I_W-1:0] fcw_int;
  logic [FCW_F_W-1:0] fcw_frac;
  logic               fcw_upd;
  logic               fcw_ack;
  logic               edge_p;
  logic [2:0]         phase_sel;
  logic               div_out;

  modport master (
    output en, fcw_int, fcw_frac, fcw_upd,
    input  fcw_ack, edge_p, phase_sel, div_out
  );

  modport slave (
    input  en, fcw_int, fcw_frac, fcw_upd,
    output fcw_ack, edge_p, phase_sel, div_out
  );
endinterface

// File: rtl/fod_phase_ctrl.sv
// Fractional output divider controller, clocked by aux-PLL phase 0.
// Counts whole aux cycles per output period and picks one of 8 phases per edge.
// Ports: clk, rst (async, active-high), bus (fod_phase_ctrl_if.slave):
//   en, fcw_int, fcw_frac, fcw_upd in; fcw_ack, edge_p, phase_sel, div_out out.
// Option: define FOD_DITHER_EN to add LFSR dither just below the phase quantum.
module fod_phase_ctrl #(
  parameter int FCW_I_W = 6,
  parameter int FCW_F_W = 16
) (
  input logic              clk,
  input logic              rst,
  fod_phase_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [FCW_I_W-1:0] cnt_q, cnt_d;
  logic [FCW_I_W-1:0] fint_q, fint_d;
  logic [FCW_F_W-1:0] ffrac_q, ffrac_d;
  logic [FCW_F_W-1:0] acc_q, acc_d;
  logic               ack_q, ack_d;
  logic               edge_q, edge_d;
  logic               div_q, div_d;
  logic [2:0]         phase_q, phase_d;

  logic [FCW_F_W:0]   sum;
  logic               carry;

  // Ratios 0 and 1 are clamped so a period never drops below 2 aux cycles.
  function automatic logic [FCW_I_W-1:0] eff_f(
    input logic [FCW_I_W-1:0] v
  );
    return (v < FCW_I_W'(2)) ? FCW_I_W'(2) : v;
  endfunction

`ifdef FOD_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[14] ^ lfsr_q[13];

  // Dither bit enters one bit below the 3-bit phase field's LSB
  assign sum = {1'b0, acc_q} + {1'b0, ffrac_q}
             + ((FCW_F_W+1)'(lfsr_q[0]) << (FCW_F_W - 4));
`else
  assign sum = {1'b0, acc_q} + {1'b0, ffrac_q};
`endif

  assign carry = sum[FCW_F_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fint_d  = fint_q;
    ffrac_d = ffrac_q;
    acc_d   = acc_q;
    ack_d   = 1'b0;
    edge_d  = 1'b0;
    div_d   = div_q;
    phase_d = phase_q;
`ifdef FOD_DITHER_EN
    lfsr_d  = lfsr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The first period is timed by the word being captured now.
        fint_d  = bus.fcw_int;
        ffrac_d = bus.fcw_frac;
        ack_d   = bus.fcw_upd;
        cnt_d   = eff_f(bus.fcw_int) - FCW_I_W'(1);
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          acc_d   = sum[FCW_F_W-1:0];
          phase_d = sum[FCW_F_W-1 -: 3];
          edge_d  = 1'b1;
          div_d   = ~div_q;
          // Reload uses the word in force; an update here governs the next one.
          cnt_d   = eff_f(fint_q) - FCW_I_W'(1)
                  + FCW_I_W'(carry);
`ifdef FOD_DITHER_EN
          lfsr_d  = {lfsr_q[13:0], lfsr_fb};
`endif
          if (bus.fcw_upd) begin
            fint_d  = bus.fcw_int;
            ffrac_d = bus.fcw_frac;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - FCW_I_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fint_q  <= '0;
      ffrac_q <= '0;
      acc_q   <= '0;
      ack_q   <= 1'b0;
      edge_q  <= 1'b0;
      div_q   <= 1'b0;
      phase_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fint_q  <= fint_d;
      ffrac_q <= ffrac_d;
      acc_q   <= acc_d;
      ack_q   <= ack_d;
      edge_q  <= edge_d;
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

`ifdef FOD_DITHER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 15'h1;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign bus.fcw_ack   = ack_q;
  assign bus.edge_p    = edge_q;
  assign bus.div_out   = div_q;
  assign bus.phase_sel = phase_q;
endmodule

// File: tb/tb_fod_phase_ctrl.sv
// Scoreboard bench for fod_phase_ctrl: an edge-time model fills queues,
// a negedge monitor pops and compares every edge_p / fcw_ack pulse.
module tb_fod_phase_ctrl;
  localparam int IW = 6;
  localparam int FW = 16;

  typedef struct {
    int cyc;
    int ph;
    int dv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fod_phase_ctrl_if #(.FCW_I_W(IW), .FCW_F_W(FW)) bus ();

  fod_phase_ctrl #(.FCW_I_W(IW), .FCW_F_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;
  exp_t edge_q[$];
  int   ack_q[$];
  exp_t mon_e;
  int   mon_a;

  int m_acc = 0;
  int m_div = 0;
  int m_phase = 0;
  bit upd_pend = 1'b0;

  always @(posedge clk) cyc++;

  function automatic int eff(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.edge_p) begin
        total++;
        if (edge_q.size() == 0) begin
          bad++;
          $display("FAIL edge_extra cyc=%0d phase=%0d div=%0d",
                   cyc, bus.phase_sel, bus.div_out);
        end else begin
          mon_e = edge_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.ph != int'(bus.phase_sel) ||
              mon_e.dv != int'(bus.div_out)) begin
            bad++;
            $display("FAIL edge got cyc=%0d ph=%0d div=%0d want cyc=%0d ph=%0d div=%0d",
                     cyc, bus.phase_sel, bus.div_out,
                     mon_e.cyc, mon_e.ph, mon_e.dv);
          end
        end
      end
      if (bus.fcw_ack) begin
        total++;
        if (ack_q.size() == 0) begin
          bad++;
          $display("FAIL ack_extra cyc=%0d", cyc);
        end else begin
          mon_a = ack_q.pop_front();
          if (mon_a != cyc) begin
            bad++;
            $display("FAIL ack got cyc=%0d want cyc=%0d", cyc, mon_a);
          end
        end
      end
    end
  end

  // One enabled run of len cycles, optional update raised uoff cycles in,
  // followed by gap idle cycles.
  task automatic run_seg(input int ii, input int ff, input int len,
                         input int uoff, input int ni, input int nf,
                         input int gap);
    int s, b, nb, ci, cf, sum, c, newu;
    bit acked;
    bit had_pend;
    @(negedge clk);
    had_pend = upd_pend;
    if (!upd_pend) begin
      bus.fcw_int  = IW'(ii);
      bus.fcw_frac = FW'(ff);
    end
    ci = int'(bus.fcw_int);
    cf = int'(bus.fcw_frac);
    bus.en = 1'b1;
    s = cyc + 1;
    if (had_pend) begin
      ack_q.push_back(s + 1);
      upd_pend = 1'b0;
    end
    newu  = (uoff >= 2 && !had_pend) ? s + uoff : -1;
    acked = 1'b0;
    b = s + 1 + eff(ci);
    while (b <= s + len - 1) begin
      sum     = m_acc + cf;
      c       = (sum >= 65536) ? 1 : 0;
      m_acc   = sum % 65536;
      m_phase = m_acc / 8192;
      m_div   = 1 - m_div;
      edge_q.push_back('{cyc: b, ph: m_phase, dv: m_div});
      nb = b + eff(ci) + c;
      if (newu >= 0 && newu <= b && !acked) begin
        ack_q.push_back(b);
        ci = ni;
        cf = nf;
        acked = 1'b1;
      end
      b = nb;
    end
    if (newu >= 0 && !acked) upd_pend = 1'b1;

    for (int j = 1; j <= len + gap; j++) begin
      @(negedge clk);
      if (bus.fcw_upd && bus.fcw_ack) bus.fcw_upd = 1'b0;
      if (j == uoff && !had_pend) begin
        bus.fcw_int  = IW'(ni);
        bus.fcw_frac = FW'(nf);
        bus.fcw_upd  = 1'b1;
      end
      if (j == len) bus.en = 1'b0;
    end

    total++;
    if (edge_q.size() != 0) begin
      bad++;
      $display("FAIL edge_missing left=%0d want=0", edge_q.size());
      edge_q.delete();
    end
    total++;
    if (ack_q.size() != 0) begin
      bad++;
      $display("FAIL ack_missing left=%0d want=0", ack_q.size());
      ack_q.delete();
    end
    total++;
    if (int'(bus.phase_sel) != m_phase || int'(bus.div_out) != m_div) begin
      bad++;
      $display("FAIL idle_hold got ph=%0d div=%0d want ph=%0d div=%0d",
               bus.phase_sel, bus.div_out, m_phase, m_div);
    end
  endtask

  function automatic int rnd_frac();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 'h2000 * int'($urandom_range(0, 7));
      2:       return 'h8000;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    int len, uoff;
    bus.en       = 1'b0;
    bus.fcw_int  = '0;
    bus.fcw_frac = '0;
    bus.fcw_upd  = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.edge_p || bus.fcw_ack || bus.div_out || bus.phase_sel != 3'd0) begin
      bad++;
      $display("FAIL reset_state got e=%0d a=%0d d=%0d p=%0d want 0",
               bus.edge_p, bus.fcw_ack, bus.div_out, bus.phase_sel);
    end
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    run_seg(4, 0, 30, -1, 0, 0, 3);
    run_seg(4, 'h2000, 80, -1, 0, 0, 4);
    run_seg(1, 0, 20, -1, 0, 0, 2);
    run_seg(0, 0, 20, -1, 0, 0, 2);
    run_seg(4, 0, 60, 10, 6, 'h8000, 3);
    run_seg(4, 0, 11, -1, 0, 0, 5);
    run_seg(4, 0, 20, -1, 0, 0, 3);
    run_seg(5, 'hE000, 40, 30, 3, 'h1234, 2);
    run_seg(7, 'h4000, 4, -1, 0, 0, 3);

    for (int k = 0; k < 40; k++) begin
      len  = int'($urandom_range(3, 60));
      uoff = ($urandom_range(0, 2) == 0) ?
             int'($urandom_range(2, len - 1)) : -1;
      run_seg(int'($urandom_range(0, 9)), rnd_frac(), len, uoff,
              int'($urandom_range(0, 9)), rnd_frac(),
              int'($urandom_range(1, 6)));
    end

    // Asynchronous reset in the middle of a run, off the clock edge
    @(negedge clk);
    mon_on = 1'b0;
    bus.fcw_upd  = 1'b0;
    upd_pend     = 1'b0;
    bus.fcw_int  = IW'(3);
    bus.fcw_frac = FW'('h3000);
    bus.en       = 1'b1;
    repeat (int'($urandom_range(8, 30))) @(negedge clk);
    #($urandom_range(1, 8));
    rst = 1'b1;
    #1;
    total++;
    if (bus.edge_p || bus.fcw_ack || bus.div_out || bus.phase_sel != 3'd0) begin
      bad++;
      $display("FAIL async_rst got e=%0d a=%0d d=%0d p=%0d want 0",
               bus.edge_p, bus.fcw_ack, bus.div_out, bus.phase_sel);
    end
    bus.en = 1'b0;
    m_acc = 0;
    m_div = 0;
    m_phase = 0;
    edge_q.delete();
    ack_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    run_seg(3, 'h3000, 40, -1, 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
